// File: rtl/spect_ahb_writer_pkg.sv
// spect_ahb_writer_pkg: AHB-Lite encodings shared by the stream-to-memory writer
package spect_ahb_writer_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
endpackage

// File: rtl/spect_ahb_writer.sv
// spect_ahb_writer: AHB-Lite master draining a 32-bit AXI-Stream into memory as pipelined SINGLE word writes
module spect_ahb_writer
  import spect_ahb_writer_pkg::*;
#(
  parameter int LW = 16
) (
  input  logic          hclk,
  input  logic          hreset,
  input  logic          ce,
  input  logic          start,
  input  logic [31:0]   base_addr,
  input  logic [LW-1:0] frame_len,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic [31:0]   tdata_s,
  input  logic          tvalid_s,
  output logic          tready_s,
  output logic [31:0]   haddr_m,
  output logic [1:0]    htrans_m,
  output logic [2:0]    hsize_m,
  output logic [2:0]    hburst_m,
  output logic          hwrite_m,
  output logic [31:0]   hwdata_m,
  input  logic          hready_m,
  input  logic          hresp_m
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;
  logic [1:0]    state_q, state_d;
  logic [31:0]   haddr_q, haddr_d, adata_q, adata_d, hwdata_q, hwdata_d;
  logic          a_vld_q, a_vld_d, d_vld_q, d_vld_d, err_q, err_d;
  logic [LW-1:0] len_q, len_d, fetched_q, fetched_d;
  logic          go, err_now, a_acc, s_acc;
  always_comb begin
    go        = start & (state_q == ST_IDLE);
    err_now   = d_vld_q & ~hready_m & (hresp_m == HRESP_ERROR);
    a_acc     = a_vld_q & hready_m;
    tready_s  = ce & (state_q == ST_RUN) & (fetched_q < len_q) & (~a_vld_q | hready_m) & ~err_now;
    s_acc     = tvalid_s & tready_s;
    haddr_d   = go ? {base_addr[31:2], 2'b00} : a_acc ? haddr_q + 32'd4 : haddr_q;
    len_d     = go ? frame_len : len_q;
    fetched_d = go ? '0 : fetched_q + LW'(s_acc);
    adata_d   = s_acc ? tdata_s : adata_q;
    a_vld_d   = ~err_now & (s_acc | (a_vld_q & ~a_acc));
    d_vld_d   = a_acc | (d_vld_q & ~hready_m);
    hwdata_d  = a_acc ? adata_q : hwdata_q;
    err_d     = ~go & (err_q | err_now);
    state_d   = (state_q == ST_IDLE)  ? (go ? ST_RUN : ST_IDLE) :
                err_now               ? ST_FLUSH :
                (state_q == ST_RUN)   ? ((fetched_q == len_q) ? ST_FLUSH : ST_RUN) :
                (state_q == ST_FLUSH) ? ((~a_vld_q & ~d_vld_q) ? ST_FIN : ST_FLUSH) :
                ST_IDLE;
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= ST_IDLE;
      haddr_q   <= '0;
      adata_q   <= '0;
      hwdata_q  <= '0;
      a_vld_q   <= 1'b0;
      d_vld_q   <= 1'b0;
      err_q     <= 1'b0;
      len_q     <= '0;
      fetched_q <= '0;
    end else begin
      state_q   <= state_d;
      haddr_q   <= haddr_d;
      adata_q   <= adata_d;
      hwdata_q  <= hwdata_d;
      a_vld_q   <= a_vld_d;
      d_vld_q   <= d_vld_d;
      err_q     <= err_d;
      len_q     <= len_d;
      fetched_q <= fetched_d;
    end
  end
  assign htrans_m = (a_vld_q & ~err_now) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr_m  = haddr_q;
  assign hwdata_m = hwdata_q;
  assign hsize_m  = HSIZE_WORD;
  assign hburst_m = HBURST_SINGLE;
  assign hwrite_m = 1'b1;
  assign busy     = state_q != ST_IDLE;
  assign done     = state_q == ST_FIN;
  assign err      = err_q;
endmodule

// File: tb/tb_spect_ahb_writer.sv
// tb_spect_ahb_writer: table-driven frames with a write scoreboard and an AHB slave model
module tb_spect_ahb_writer;
  logic        hclk = 1'b0, hreset = 1'b1, ce = 1'b1, start = 1'b0;
  logic [31:0] base_addr = '0, tdata_s = '0;
  logic [15:0] frame_len = '0;
  logic        tvalid_s = 1'b0, hready_m = 1'b1, hresp_m = 1'b0;
  logic        busy, done, err, tready_s, hwrite_m;
  logic [31:0] haddr_m, hwdata_m;
  logic [1:0]  htrans_m;
  logic [2:0]  hsize_m, hburst_m;
  spect_ahb_writer #(.LW(16)) dut (
    .hclk(hclk), .hreset(hreset), .ce(ce), .start(start), .base_addr(base_addr),
    .frame_len(frame_len), .busy(busy), .done(done), .err(err), .tdata_s(tdata_s),
    .tvalid_s(tvalid_s), .tready_s(tready_s), .haddr_m(haddr_m), .htrans_m(htrans_m),
    .hsize_m(hsize_m), .hburst_m(hburst_m), .hwrite_m(hwrite_m), .hwdata_m(hwdata_m),
    .hready_m(hready_m), .hresp_m(hresp_m)
  );
  always #5 hclk = ~hclk;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  typedef struct {
    logic [31:0] base;
    logic [15:0] len;
    logic [31:0] d0;
    int          stall_idx;
    int          stall_n;
    int          err_idx;
    bit          gap;
    bit          ce_gap;
    int          n_wr;
    int          exp_ns;
    bit          consec;
    logic        exp_err;
  } frame_t;
  exp_t   sb[$];
  exp_t   mon_e;
  frame_t tbl[5];
  int checks = 0, errors = 0;
  int stall_abs = -1, stall_n = 0, err_abs = -1;
  int resp_seen = 0, wait_left = 0, err_st = 0;
  int dph_cnt = 0, writes = 0;
  bit mon_en = 1'b0, dph_active = 1'b0, ns_prev = 1'b0, rdy_prev = 1'b1, dstall_prev = 1'b0;
  logic [31:0] addr_rec = '0, addr_prev = '0, hw_prev = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask
  // slave model: wait states / two-cycle ERROR on chosen data phases
  always @(posedge hclk) begin
    #1;
    if (dph_active && resp_seen != dph_cnt) begin
      resp_seen = dph_cnt;
      if (dph_cnt - 1 == stall_abs) wait_left = stall_n;
      if (dph_cnt - 1 == err_abs) err_st = 1;
    end
    if (!dph_active) begin
      hready_m = 1'b1;
      hresp_m  = 1'b0;
    end else if (err_st == 1) begin
      hready_m = 1'b0;
      hresp_m  = 1'b1;
      err_st   = 2;
    end else if (err_st == 2) begin
      hready_m = 1'b1;
      hresp_m  = 1'b1;
      err_st   = 0;
    end else if (wait_left > 0) begin
      hready_m = 1'b0;
      hresp_m  = 1'b0;
      wait_left--;
    end else begin
      hready_m = 1'b1;
      hresp_m  = 1'b0;
    end
  end
  // bus monitor: pairs address and data phases and pops the scoreboard
  always @(negedge hclk) begin
    if (!mon_en) begin
      dph_active  = 1'b0;
      ns_prev     = 1'b0;
      rdy_prev    = 1'b1;
      dstall_prev = 1'b0;
    end else begin
      if (dph_active && hready_m) begin
        writes++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_write: got addr %h data %h expected no write", addr_rec, hwdata_m);
        end else begin
          mon_e = sb.pop_front();
          chk("wr_addr", addr_rec, mon_e.addr);
          chk("wr_data", hwdata_m, mon_e.data);
        end
      end
      if (dstall_prev) chk("hwdata_hold", hwdata_m, hw_prev);
      if (ns_prev && !rdy_prev) begin
        chk("htrans_hold", 32'(htrans_m), 32'h2);
        chk("haddr_hold", haddr_m, addr_prev);
      end
      if (hresp_m && !hready_m) chk("err_idle", 32'(htrans_m), 0);
      if (hresp_m) chk("err_tready", 32'(tready_s), 0);
      if (!hready_m && htrans_m == 2'b10) chk("full_tready", 32'(tready_s), 0);
      dstall_prev = dph_active && !hready_m;
      if (hready_m) begin
        dph_active = htrans_m == 2'b10;
        addr_rec   = haddr_m;
        if (dph_active) dph_cnt++;
      end
      ns_prev   = htrans_m == 2'b10;
      rdy_prev  = hready_m;
      addr_prev = haddr_m;
      hw_prev   = hwdata_m;
    end
  end
  task automatic run_frame(input frame_t f);
    int sent = 0, ns = 0, ns_first = -1, ns_last = -1, w0;
    bit dn = 1'b0;
    w0 = writes;
    stall_abs = (f.stall_idx < 0) ? -1 : dph_cnt + f.stall_idx;
    stall_n   = f.stall_n;
    err_abs   = (f.err_idx < 0) ? -1 : dph_cnt + f.err_idx;
    base_addr = f.base;
    frame_len = f.len;
    start     = 1'b1;
    @(posedge hclk); #1;
    start = 1'b0;
    chk("busy_start", 32'(busy), 1);
    chk("err_cleared", 32'(err), 0);
    for (int k = 0; k < 300 && !dn; k++) begin
      tvalid_s = (sent < int'(f.len)) && !(f.gap && (k % 2) != 0);
      tdata_s  = f.d0 + 32'(sent);
      ce       = !(f.ce_gap && k >= 2 && k < 5);
      @(negedge hclk);
      if (!ce) chk("ce_tready", 32'(tready_s), 0);
      if (htrans_m == 2'b10) begin
        ns++;
        if (ns_first < 0) ns_first = k;
        ns_last = k;
      end
      if (tvalid_s && tready_s) begin
        if (sent < f.n_wr) sb.push_back('{f.base + 32'(4 * sent), f.d0 + 32'(sent)});
        sent++;
      end
      if (done) dn = 1'b1;
      @(posedge hclk); #1;
    end
    tvalid_s = 1'b0;
    ce       = 1'b1;
    if (!dn) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 300 cycles");
    end
    @(negedge hclk);
    chk("done_pulse", 32'(done), 0);
    chk("busy_end", 32'(busy), 0);
    chk("err_end", 32'(err), 32'(f.exp_err));
    chk("write_count", writes - w0, f.n_wr);
    chk("sb_empty", sb.size(), 0);
    chk("ns_cycles", ns, f.exp_ns);
    if (f.consec) chk("ns_consec", ns_last - ns_first + 1, ns);
    @(posedge hclk); #1;
  endtask
  initial begin
    tbl[0] = '{32'h2000_0000, 16'd4, 32'hA0, -1, 0, -1, 1'b0, 1'b0, 4, 4, 1'b1, 1'b0};
    tbl[1] = '{32'h2000_0000, 16'd4, 32'hA0,  1, 2, -1, 1'b0, 1'b0, 4, 6, 1'b1, 1'b0};
    tbl[2] = '{32'h2100_0000, 16'd4, 32'hB0, -1, 0, -1, 1'b1, 1'b1, 4, 4, 1'b0, 1'b0};
    tbl[3] = '{32'h2200_0000, 16'd3, 32'hE0, -1, 0,  1, 1'b0, 1'b0, 2, 2, 1'b1, 1'b1};
    tbl[4] = '{32'hFFFF_FFFC, 16'd2, 32'hF0, -1, 0, -1, 1'b0, 1'b0, 2, 2, 1'b1, 1'b0};
    repeat (3) @(posedge hclk);
    #1;
    @(negedge hclk);
    chk("rst_htrans", 32'(htrans_m), 0);
    chk("rst_haddr", haddr_m, 0);
    chk("rst_hwdata", hwdata_m, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_tready", 32'(tready_s), 0);
    chk("hsize", 32'(hsize_m), 32'h2);
    chk("hburst", 32'(hburst_m), 0);
    chk("hwrite", 32'(hwrite_m), 1);
    @(posedge hclk); #1;
    hreset = 1'b0;
    mon_en = 1'b1;
    @(posedge hclk); #1;
    sb.push_back('{32'h1000_0000, 32'h55});
    base_addr = 32'h1000_0003;
    frame_len = 16'd1;
    start     = 1'b1;
    tvalid_s  = 1'b1;
    tdata_s   = 32'h55;
    @(posedge hclk); #1;
    start = 1'b0;
    @(negedge hclk);
    chk("lat_tready_c1", 32'(tready_s), 1);
    @(posedge hclk); #1;
    tvalid_s = 1'b0;
    @(negedge hclk);
    chk("lat_nonseq_c2", 32'(htrans_m), 32'h2);
    chk("lat_haddr_c2", haddr_m, 32'h1000_0000);
    @(negedge hclk);
    chk("lat_hwdata_c3", hwdata_m, 32'h55);
    for (int k = 0; k < 20 && !done; k++) @(negedge hclk);
    chk("lat_done", 32'(done), 1);
    @(posedge hclk); #1;
    for (int i = 0; i < 5; i++) run_frame(tbl[i]);
    base_addr = 32'h5000_0000;
    frame_len = 16'd0;
    start     = 1'b1;
    @(posedge hclk); #1;
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge hclk);
      chk("len0_done", 32'(done), (c == 3) ? 1 : 0);
      chk("len0_idle", 32'(htrans_m), 0);
      @(posedge hclk); #1;
    end
    @(negedge hclk);
    chk("len0_busy", 32'(busy), 0);
    @(posedge hclk); #1;
    mon_en    = 1'b0;
    base_addr = 32'h3000_0000;
    frame_len = 16'd4;
    start     = 1'b1;
    tvalid_s  = 1'b1;
    tdata_s   = 32'hC0;
    @(posedge hclk); #1;
    start = 1'b0;
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset   = 1'b0;
    tvalid_s = 1'b0;
    @(negedge hclk);
    chk("mid_rst_htrans", 32'(htrans_m), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_haddr", haddr_m, 0);
    sb.delete();
    @(posedge hclk); #1;
    mon_en = 1'b1;
    @(posedge hclk); #1;
    run_frame('{32'h4000_0000, 16'd3, 32'hD0, -1, 0, -1, 1'b0, 1'b0, 3, 3, 1'b1, 1'b0});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
